// File: rtl/stream_demux2.sv
// Registered 1-to-2 valid/ready demultiplexer: in_sel = 1 steers to channel A, 0 to channel B.
// Define DEMUX2_SKID_EN for a 2-entry skid buffer per channel with a registered in_ready.

module stream_demux2_chan #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             accept_o
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } chan_state_e;

   chan_state_e      state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             pop;

   assign pop     = ready_i & (state_q != EMPTY);
   assign valid_o = (state_q != EMPTY);
   assign data_o  = head_q;

`ifdef DEMUX2_SKID_EN
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             accept_q;
`endif

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
`ifdef DEMUX2_SKID_EN
      skid_d  = skid_q;
`endif
      case (state_q)
         EMPTY: begin
            if (push_i) begin
               state_d = ONE;
               head_d  = wdata_i;
            end
         end
         ONE: begin
            if (push_i && pop) begin
               head_d = wdata_i;
`ifdef DEMUX2_SKID_EN
            end else if (push_i) begin
               state_d = TWO;
               skid_d  = wdata_i;
`endif
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
`ifdef DEMUX2_SKID_EN
         TWO: begin
            // accept_q is low in TWO, so only a pop can happen here
            if (pop) begin
               state_d = ONE;
               head_d  = skid_q;
            end
         end
`endif
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= EMPTY;
         head_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
      end
   end

`ifdef DEMUX2_SKID_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         skid_q   <= '0;
         accept_q <= 1'b1;
      end else begin
         skid_q   <= skid_d;
         accept_q <= (state_d != TWO);
      end
   end

   assign accept_o = accept_q;
`else
   // Single entry: a full channel can still take a word while its consumer drains it
   assign accept_o = (state_q == EMPTY) | ready_i;
`endif
endmodule

module stream_demux2 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             out_a_valid,
   input  logic             out_a_ready,
   output logic [WIDTH-1:0] out_a_data,
   output logic             out_b_valid,
   input  logic             out_b_ready,
   output logic [WIDTH-1:0] out_b_data
);
   logic accept_a, accept_b;
   logic push_a, push_b;

   // rstn gates in_ready so it drops the instant reset asserts
   assign in_ready = rstn & (in_sel ? accept_a : accept_b);
   assign push_a   = in_valid & in_ready & in_sel;
   assign push_b   = in_valid & in_ready & ~in_sel;

   stream_demux2_chan #(.WIDTH(WIDTH)) u_chan_a (
      .clk      (clk),
      .rstn     (rstn),
      .push_i   (push_a),
      .wdata_i  (in_data),
      .ready_i  (out_a_ready),
      .valid_o  (out_a_valid),
      .data_o   (out_a_data),
      .accept_o (accept_a)
   );

   stream_demux2_chan #(.WIDTH(WIDTH)) u_chan_b (
      .clk      (clk),
      .rstn     (rstn),
      .push_i   (push_b),
      .wdata_i  (in_data),
      .ready_i  (out_b_ready),
      .valid_o  (out_b_valid),
      .data_o   (out_b_data),
      .accept_o (accept_b)
   );
endmodule

// File: tb/tb_stream_demux2.sv
// Scoreboard bench for stream_demux2; compile with or without DEMUX2_SKID_EN to match the RTL build.

module tb_stream_demux2;
`ifdef DEMUX2_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_sel = 1'b0;
   logic        out_a_valid;
   logic        out_a_ready = 1'b0;
   logic [15:0] out_a_data;
   logic        out_b_valid;
   logic        out_b_ready = 1'b0;
   logic [15:0] out_b_data;

   int checks = 0;
   int failures = 0;

   logic [15:0] exp_a[$];
   logic [15:0] exp_b[$];

   logic        stall_a = 1'b0, stall_b = 1'b0;
   logic [15:0] held_a = '0, held_b = '0;

   always #5 clk = ~clk;

   stream_demux2 #(.WIDTH(16)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_sel      (in_sel),
      .out_a_valid (out_a_valid),
      .out_a_ready (out_a_ready),
      .out_a_data  (out_a_data),
      .out_b_valid (out_b_valid),
      .out_b_ready (out_b_ready),
      .out_b_data  (out_b_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: inputs are stable from posedge+1 to the next posedge, so the
   // negedge sees exactly the handshakes that the coming edge will perform.
   always @(negedge clk) begin
      if (rstn) begin
         int  occ;
         logic rdy, exp_rdy;
         check("a_valid", 32'(out_a_valid), 32'(exp_a.size() != 0));
         if (exp_a.size() != 0) check("a_data", 32'(out_a_data), 32'(exp_a[0]));
         check("b_valid", 32'(out_b_valid), 32'(exp_b.size() != 0));
         if (exp_b.size() != 0) check("b_data", 32'(out_b_data), 32'(exp_b[0]));
         if (stall_a) check("a_stall_hold", 32'({out_a_valid, out_a_data}), 32'({1'b1, held_a}));
         if (stall_b) check("b_stall_hold", 32'({out_b_valid, out_b_data}), 32'({1'b1, held_b}));

         occ     = in_sel ? exp_a.size() : exp_b.size();
         rdy     = in_sel ? out_a_ready : out_b_ready;
         exp_rdy = (occ < CAP) || (CAP == 1 && rdy);
         check("in_ready", 32'(in_ready), 32'(exp_rdy));

         stall_a = out_a_valid && !out_a_ready;
         held_a  = out_a_data;
         stall_b = out_b_valid && !out_b_ready;
         held_b  = out_b_data;

         if (out_a_valid && out_a_ready && exp_a.size() != 0) void'(exp_a.pop_front());
         if (out_b_valid && out_b_ready && exp_b.size() != 0) void'(exp_b.pop_front());
         if (in_valid && in_ready) begin
            if (in_sel) exp_a.push_back(in_data);
            else        exp_b.push_back(in_data);
         end
      end else begin
         stall_a = 1'b0;
         stall_b = 1'b0;
      end
   end

   initial begin
      logic held;

      // Reset values
      #2;
      check("rst_a_valid", 32'(out_a_valid), 32'd0);
      check("rst_b_valid", 32'(out_b_valid), 32'd0);
      check("rst_a_data", 32'(out_a_data), 32'd0);
      check("rst_b_data", 32'(out_b_data), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) step();
      rstn = 1'b1;

      // Single word to A
      in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h1234;
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      #1;
      check("t1_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("t1_a_valid", 32'(out_a_valid), 32'd1);
      check("t1_a_data", 32'(out_a_data), 32'h1234);
      check("t1_b_valid", 32'(out_b_valid), 32'd0);
      step();

      // Alternating stream, both consumers ready: never stalls
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_sel = i[0]; in_data = 16'(i);
         #1;
         check("t2_no_stall", 32'(in_ready), 32'd1);
         step();
      end
      in_valid = 1'b0;
      repeat (2) step();

      // Stalled channel B
      out_b_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hAAAA;
      step();
      in_valid = 1'b0; in_sel = 1'b1;
      #1;
      check("t3_ready_sel1", 32'(in_ready), 32'd1);
      in_sel = 1'b0;
      #1;
      check("t3_ready_sel0", 32'(in_ready), 32'(CAP == 2));
      in_valid = 1'b1; in_data = 16'hBBBB;
      step();
      check("t3_ready_full", 32'(in_ready), 32'd0);
      if (CAP == 2) in_valid = 1'b0;
      out_b_ready = 1'b1;
      #1;
      check("t3_b_first", 32'(out_b_data), 32'hAAAA);
      step();
      in_valid = 1'b0;
      check("t3_b_second_v", 32'(out_b_valid), 32'd1);
      check("t3_b_second", 32'(out_b_data), 32'hBBBB);
      repeat (2) step();

      // Push and pop on A in the same cycle
      in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h1111;
      step();
      in_data = 16'h2222;
      #1;
      check("t4_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("t4_a_valid", 32'(out_a_valid), 32'd1);
      check("t4_a_data", 32'(out_a_data), 32'h2222);
      repeat (2) step();

      // Asynchronous reset while both channels hold data
      out_a_ready = 1'b0; out_b_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h5555;
      step();
      in_sel = 1'b0; in_data = 16'h6666;
      step();
      in_valid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      check("t5_a_valid", 32'(out_a_valid), 32'd0);
      check("t5_b_valid", 32'(out_b_valid), 32'd0);
      check("t5_a_data", 32'(out_a_data), 32'd0);
      check("t5_b_data", 32'(out_b_data), 32'd0);
      check("t5_in_ready", 32'(in_ready), 32'd0);
      exp_a.delete();
      exp_b.delete();
      @(posedge clk);
      #2;
      rstn = 1'b1;
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      repeat (3) step();

      // Random traffic; a stalled offer is held unchanged
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         held = in_valid && !in_ready;
         @(posedge clk);
         #1;
         if (!held) begin
            in_valid = ($urandom_range(3) != 0);
            in_sel   = 1'($urandom_range(1));
            in_data  = 16'($urandom);
         end
         out_a_ready = ($urandom_range(2) != 0);
         out_b_ready = ($urandom_range(3) == 0) ? 1'b0 : 1'($urandom_range(1));
      end
      @(negedge clk);
      held = in_valid && !in_ready;
      @(posedge clk);
      #1;
      if (!held) in_valid = 1'b0;
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (6) step();
      check("drain_a", 32'(exp_a.size()), 32'd0);
      check("drain_b", 32'(exp_b.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/stream_demux2.md
# stream_demux2

Registered 1-to-2 stream demultiplexer: the routing counterpart of the 2-input mux, steering one valid/ready input stream to one of two output streams under a select bit. It sits between a single producer (e.g. a decode or writeback stage) and two consumers, and holds each routed word in a per-output register until that consumer accepts it. The select polarity matches the team's 2-input mux: sel = 1 routes to channel A, sel = 0 routes to channel B.

## Interface
- WIDTH, 16, data width of input and both outputs
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  producer offers a word
- in_ready  out  1  block accepts the word this cycle
- in_data  in  WIDTH  input word
- in_sel  in  1  destination: 1 = channel A, 0 = channel B
- out_a_valid  out  1  channel A holds a word
- out_a_ready  in  1  channel A consumer accepts
- out_a_data  out  WIDTH  channel A word
- out_b_valid  out  1  channel B holds a word
- out_b_ready  in  1  channel B consumer accepts
- out_b_data  out  WIDTH  channel B word

## Operation
- Transfer occurs on a rising clk edge when valid & ready are both high; this applies to the input port and to each output port.
- Producer rule: while in_valid & ~in_ready, in_data and in_sel must stay stable.
- Output rule: once out_x_valid rises, out_x_data stays stable and out_x_valid stays high until out_x_ready is sampled high.
- Each channel is an independent buffer with states EMPTY and ONE. With the skid option enabled, each channel also has state TWO.
- Channel transitions:
  - Push only: EMPTY→ONE, ONE→TWO.
  - Pop only: ONE→EMPTY, TWO→ONE.
  - Push and pop in the same cycle: state is unchanged, and the data shifts.
- A push goes only to the channel selected by in_sel. The unselected channel sees no push.
- Ordering is FIFO within each channel. There is no ordering guarantee between channels.
- Both channels may pop in the same cycle, independently of any push.
- in_ready is driven by the selected channel's condition, so it is valid only for the current in_sel.
- Reset (rstn low, at any time including mid-transfer):
  - Both channels go to EMPTY immediately.
  - out_a_valid = out_b_valid = 0.
  - out_a_data = out_b_data = 0.
  - in_ready = 0.
  - Any in-flight word is discarded.
  - After rstn rises, in_ready follows the rules below from the first clock.

## Timing
- Latency: a word accepted at edge N is presented on its output with valid high in the cycle after edge N (1 cycle).
- Throughput: 1 word per cycle into either channel while that channel's consumer holds ready high.
- Data registers load only on push or shift. They hold at all other times.
- No combinational path from in_valid or in_data to any output.

## Configuration
- Macro: DEMUX2_SKID_EN.
- Undefined (1-entry per channel):
  - in_ready = ~in_sel-selected channel full, OR that channel's out_x_ready. This is a combinational path from out_x_ready to in_ready.
  - Full-rate streaming works when the consumer's ready is held high.
- Defined (2-entry skid per channel):
  - in_ready = registered "selected channel not in TWO", i.e. a mux of two flops. There is no combinational path from out_x_ready.
  - When a consumer stalls, the word arriving in the stall cycle lands in the skid entry (state TWO). It is emitted after the main entry, in order.
- Both builds: same ports, same 1-cycle latency, same reset values.

## Test plan
- Reset release, then in_valid = 1, in_sel = 1, in_data = 0x1234, out_a_ready = 1 → in_ready = 1; the next cycle out_a_valid = 1 with 0x1234. out_b_valid stays 0 throughout.
- Alternating stream 0x0001..0x0008 with in_sel toggling 1,0,1,…, both readies high → A receives 0x0001, 3, 5, 7 and B receives 0x0002, 4, 6, 8, each in order, with no stall cycles.
- out_b_ready = 0, then push 0xAAAA to B:
  - Without the macro: after one push, in_ready = 0 for in_sel = 0 and 1 for in_sel = 1.
  - With the macro: B accepts a second word 0xBBBB, then in_ready drops.
  - After out_b_ready rises, B emits 0xAAAA then 0xBBBB.
- Simultaneous push to A and pop from A in a full-ONE state (out_a_ready = 1) → the state stays ONE, out_a_data updates to the new word next cycle, and no word is lost.
- rstn pulsed low asynchronously mid-cycle while both channels hold data → out_a_valid, out_b_valid, out_a_data, out_b_data and in_ready go to 0 immediately. After release, old data never appears.
- Random valid/ready/sel for 10k cycles against a two-queue scoreboard, in both macro builds → per-channel order and content match, and no data changes while a channel is stalled.
